// File: rtl/cal_capture_pkg.sv
// -----------------------------------------------------------------------------
// cal_capture_pkg
// Shared definitions for the offset-capture engine and the calibrator that
// consumes its coefficient writes.
//   - cal_state_t     : capture state machine encoding
//   - ch_idx_t        : 3-bit channel index (8 channels)
//   - coef_addr_t     : 4-bit coefficient-memory address
//   - offset_addr()   : offset slot {ch,1'b0}
//   - mult_addr()     : multiply slot {ch,1'b1}
// -----------------------------------------------------------------------------
package cal_capture_pkg;

    localparam int W_SAMPLE   = 16;
    localparam int N_CHANNELS = 8;

    typedef logic [2:0] ch_idx_t;
    typedef logic [3:0] coef_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_FS,
        ACCUM,
        EMIT
    } cal_state_t;

    // Each channel owns two adjacent coefficient words: offset then multiplier.
    function automatic coef_addr_t offset_addr(input ch_idx_t ch);
        return {ch, 1'b0};
    endfunction

    function automatic coef_addr_t mult_addr(input ch_idx_t ch);
        return {ch, 1'b1};
    endfunction

endpackage

// File: rtl/cal_capture_if.sv
// -----------------------------------------------------------------------------
// cal_capture_if
// Valid/ready write port into the calibrator coefficient memory.
//   wr_valid : word available (master -> slave)
//   wr_ready : consumer accepts word (slave -> master)
//   wr_addr  : coefficient address (master -> slave)
//   wr_data  : signed coefficient word, W bits (master -> slave)
// -----------------------------------------------------------------------------
interface cal_capture_if #(
    parameter int W = 16
);
    logic                wr_valid;
    logic                wr_ready;
    logic [3:0]          wr_addr;
    logic signed [W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/cal_capture_round_sat.sv
// -----------------------------------------------------------------------------
// cal_round_sat
// Combinational divide-by-2^SH with round-half-up and saturation from a
// (W+SH)-bit signed accumulator down to a W-bit signed word.
// Ports:
//   acc_i : signed accumulator, W+SH bits
//   avg_o : signed rounded/saturated result, W bits
// -----------------------------------------------------------------------------
module cal_round_sat #(
    parameter int W  = 16,
    parameter int SH = 8      // shift amount, must be >= 1
) (
    input  logic signed [W+SH-1:0] acc_i,
    output logic signed [W-1:0]    avg_o
);

    localparam int AW = W + SH;

    // One guard bit above the accumulator so the bias add can never wrap.
    localparam logic signed [AW:0] BIAS    = (AW+1)'(1) << (SH - 1);
    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = -((AW+1)'(2 ** (W - 1)));

    function automatic logic signed [AW:0] round_half_up(input logic signed [AW-1:0] a);
        logic signed [AW:0] s;
        s = {a[AW-1], a};
        s = s + BIAS;
        return s >>> SH;
    endfunction

    function automatic logic signed [W-1:0] saturate(input logic signed [AW:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return v[W-1:0];
        end
    endfunction

    assign avg_o = saturate(round_half_up(acc_i));

endmodule

// File: rtl/cal_capture.sv
// -----------------------------------------------------------------------------
// cal_capture
// Offset-capture engine. While all inputs sit at the 0 V reference it sums
// 2^LOG2_N_AVG frames of raw samples per channel, then writes one rounded
// DC-offset word per channel to the coefficient memory at {ch,1'b0}.
// Ports:
//   clk_256fs : system clock (256x sample rate)
//   rst       : synchronous reset, active-high
//   clk_fs    : sample-rate strobe, edge-detected in clk_256fs domain
//   start     : one-cycle capture request (ignored while busy)
//   in0..in7  : raw signed samples, W bits
//   wr        : coefficient write port (cal_capture_if.master)
//   busy      : capture in progress
//   done      : one-cycle pulse after the last word is accepted
//   noisy     : per-channel peak-to-peak flag (only with CAL_CAPTURE_NOISE_EN)
// Optional feature macro: CAL_CAPTURE_NOISE_EN adds parameter NOISE_PP_MAX,
// per-channel min/max tracking and the noisy[7:0] output.
// -----------------------------------------------------------------------------
module cal_capture
    import cal_capture_pkg::*;
#(
    parameter int W          = W_SAMPLE,
    parameter int LOG2_N_AVG = 8
`ifdef CAL_CAPTURE_NOISE_EN
    ,
    parameter int NOISE_PP_MAX = 64
`endif
) (
    input  logic                clk_256fs,
    input  logic                rst,
    input  logic                clk_fs,
    input  logic                start,
    input  logic signed [W-1:0] in0,
    input  logic signed [W-1:0] in1,
    input  logic signed [W-1:0] in2,
    input  logic signed [W-1:0] in3,
    input  logic signed [W-1:0] in4,
    input  logic signed [W-1:0] in5,
    input  logic signed [W-1:0] in6,
    input  logic signed [W-1:0] in7,
    cal_capture_if.master       wr,
    output logic                busy,
    output logic                done
`ifdef CAL_CAPTURE_NOISE_EN
    ,
    output logic [7:0]          noisy
`endif
);

    localparam int AW = W + LOG2_N_AVG;
    localparam int FW = LOG2_N_AVG + 1;
    localparam logic [FW-1:0] N_FRAMES = FW'(1) << LOG2_N_AVG;

    logic signed [W-1:0] samp [N_CHANNELS];

    assign samp[0] = in0;
    assign samp[1] = in1;
    assign samp[2] = in2;
    assign samp[3] = in3;
    assign samp[4] = in4;
    assign samp[5] = in5;
    assign samp[6] = in6;
    assign samp[7] = in7;

    cal_state_t           state_q;
    ch_idx_t              ch_q;
    logic [FW-1:0]        frame_q;
    logic signed [AW-1:0] acc_q [N_CHANNELS];
    logic                 l_clk_fs_q;
    logic                 wr_valid_q;
    coef_addr_t           wr_addr_q;
    logic signed [W-1:0]  wr_data_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 fs_rise_d;
    logic signed [AW-1:0] acc_sum_d;
    ch_idx_t              emit_sel_d;
    logic signed [W-1:0]  avg_d;

    assign fs_rise_d = clk_fs && !l_clk_fs_q;
    assign acc_sum_d = acc_q[ch_q] + {{LOG2_N_AVG{samp[ch_q][W-1]}}, samp[ch_q]};

    // The rounder always looks one channel ahead so the next offset word is
    // ready to load on the cycle a handshake completes. On the final ACCUM
    // cycle ch_q is 7, so this wraps to channel 0 for EMIT entry.
    assign emit_sel_d = ch_q + 3'd1;

    cal_round_sat #(
        .W  (W),
        .SH (LOG2_N_AVG)
    ) u_round_sat (
        .acc_i (acc_q[emit_sel_d]),
        .avg_o (avg_d)
    );

`ifdef CAL_CAPTURE_NOISE_EN
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] min_q  [N_CHANNELS];
    logic signed [W-1:0] max_q  [N_CHANNELS];
    logic signed [W-1:0] min_nx [N_CHANNELS];
    logic signed [W-1:0] max_nx [N_CHANNELS];
    logic signed [W:0]   pp_d   [N_CHANNELS];
    logic [7:0]          noisy_d;
    logic [7:0]          noisy_q;

    // Include the sample being accumulated this cycle so channel 7's last
    // sample is seen by the flag computed at EMIT entry.
    always_comb begin
        noisy_d = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            min_nx[i] = min_q[i];
            max_nx[i] = max_q[i];
            if (state_q == ACCUM && ch_q == ch_idx_t'(i)) begin
                if (samp[i] < min_q[i]) min_nx[i] = samp[i];
                if (samp[i] > max_q[i]) max_nx[i] = samp[i];
            end
            pp_d[i]    = {max_nx[i][W-1], max_nx[i]} - {min_nx[i][W-1], min_nx[i]};
            noisy_d[i] = (pp_d[i] > NOISE_PP_MAX);
        end
    end

    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            noisy_q <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                min_q[i] <= '0;
                max_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: if (start) noisy_q <= '0;
                CLEAR: begin
                    min_q[ch_q] <= S_MAX;
                    max_q[ch_q] <= S_MIN;
                end
                ACCUM: begin
                    for (int i = 0; i < N_CHANNELS; i++) begin
                        min_q[i] <= min_nx[i];
                        max_q[i] <= max_nx[i];
                    end
                    if (ch_q == 3'd7 && (frame_q + FW'(1)) == N_FRAMES) begin
                        noisy_q <= noisy_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign noisy = noisy_q;
`endif

    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            frame_q    <= '0;
            l_clk_fs_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            l_clk_fs_q <= clk_fs;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        ch_q    <= '0;
                    end
                end
                CLEAR: begin
                    acc_q[ch_q] <= '0;
                    frame_q     <= '0;
                    ch_q        <= ch_q + 3'd1;
                    if (ch_q == 3'd7) state_q <= WAIT_FS;
                end
                WAIT_FS: begin
                    // Only edges seen in this state start a frame, so edges
                    // coinciding with start or CLEAR are dropped.
                    if (fs_rise_d) begin
                        state_q <= ACCUM;
                        ch_q    <= '0;
                    end
                end
                ACCUM: begin
                    acc_q[ch_q] <= acc_sum_d;
                    ch_q        <= ch_q + 3'd1;
                    if (ch_q == 3'd7) begin
                        frame_q <= frame_q + FW'(1);
                        if ((frame_q + FW'(1)) == N_FRAMES) begin
                            state_q    <= EMIT;
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= offset_addr(3'd0);
                            wr_data_q  <= avg_d;
                        end else begin
                            state_q <= WAIT_FS;
                        end
                    end
                end
                EMIT: begin
                    if (wr.wr_ready) begin
                        if (ch_q == 3'd7) begin
                            wr_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            ch_q      <= ch_q + 3'd1;
                            wr_addr_q <= offset_addr(ch_q + 3'd1);
                            wr_data_q <= avg_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_cal_capture.sv
// -----------------------------------------------------------------------------
// tb_cal_capture
// Self-checking bench for cal_capture at LOG2_N_AVG=2 (4-frame averages).
// Frames are driven one clk_fs period at a time after each start, and the
// expected offset words come from a plain-arithmetic average of those frames.
// -----------------------------------------------------------------------------
module tb_cal_capture;
    import cal_capture_pkg::*;

    localparam int W  = 16;
    localparam int L  = 2;
    localparam int NF = 1 << L;

    logic                clk = 1'b0;
    logic                rst;
    logic                clk_fs;
    logic                start;
    logic signed [W-1:0] in_s [8];
    logic                busy;
    logic                done;
`ifdef CAL_CAPTURE_NOISE_EN
    logic [7:0]          noisy;
`endif

    cal_capture_if #(.W(W)) wr_if ();

    always #5 clk = ~clk;

    cal_capture #(
        .W          (W),
        .LOG2_N_AVG (L)
    ) dut (
        .clk_256fs (clk),
        .rst       (rst),
        .clk_fs    (clk_fs),
        .start     (start),
        .in0       (in_s[0]),
        .in1       (in_s[1]),
        .in2       (in_s[2]),
        .in3       (in_s[3]),
        .in4       (in_s[4]),
        .in5       (in_s[5]),
        .in6       (in_s[6]),
        .in7       (in_s[7]),
        .wr        (wr_if),
        .busy      (busy),
        .done      (done)
`ifdef CAL_CAPTURE_NOISE_EN
        ,
        .noisy     (noisy)
`endif
    );

    typedef struct packed {
        logic [7:0][15:0] in_v;
        logic [7:0][15:0] exp_v;
    } vec_t;

    int fr [NF][8];
    int exp_d [8];
    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Reference: mean of the frames, rounded half-up, clamped to W bits.
    function automatic void model();
        for (int c = 0; c < 8; c++) begin
            longint s;
            s = 0;
            for (int f = 0; f < NF; f++) s += fr[f][c];
            s = (s + NF / 2) >>> L;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_d[c] = int'(s);
        end
    endfunction

    function automatic void rand_frames();
        logic [15:0] r;
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 8; c++) begin
                r = 16'($urandom);
                fr[f][c] = int'($signed(r));
            end
    endfunction

    task automatic run_frames(input int restart_f);
        for (int f = 0; f < NF; f++) begin
            for (int c = 0; c < 8; c++) in_s[c] = W'(fr[f][c]);
            repeat (2) @(negedge clk);
            clk_fs = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                start = (f == restart_f && k == 2);
            end
            start  = 1'b0;
            clk_fs = 1'b0;
            if (f != NF - 1) repeat (6) @(negedge clk);
        end
    endtask

    task automatic capture(input int restart_f);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        repeat (10) @(negedge clk);
        run_frames(restart_f);
    endtask

    task automatic collect(input int stall_ch, input int stall_len);
        int nacc   = 0;
        int stalls = 0;
        int ndone  = 0;
        int gaps   = 0;
        int cyc    = 0;
        logic [3:0]          sa = '0;
        logic signed [W-1:0] sd = '0;
        while (ndone == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                chk("busy_at_done", longint'(busy), 0);
                chk("valid_at_done", longint'(wr_if.wr_valid), 0);
            end else if (nacc > 0 && nacc < 8 && !wr_if.wr_valid) begin
                gaps++;
            end
            if (wr_if.wr_valid) begin
                if (stalls > 0 && nacc == stall_ch) begin
                    chk("stall_addr", longint'(wr_if.wr_addr), longint'(sa));
                    chk("stall_data", longint'(wr_if.wr_data), longint'(sd));
                end
                if (nacc == stall_ch && stalls < stall_len) begin
                    if (stalls == 0) begin
                        sa = wr_if.wr_addr;
                        sd = wr_if.wr_data;
                    end
                    stalls++;
                    wr_if.wr_ready = 1'b0;
                end else begin
                    wr_if.wr_ready = 1'b1;
                    if (nacc < 8) begin
                        chk($sformatf("addr_w%0d", nacc), longint'(wr_if.wr_addr), nacc * 2);
                        chk($sformatf("data_w%0d", nacc), longint'(wr_if.wr_data), exp_d[nacc]);
                    end
                    nacc++;
                end
            end else begin
                wr_if.wr_ready = 1'b1;
            end
        end
        wr_if.wr_ready = 1'b1;
        chk("word_count", nacc, 8);
        chk("done_pulses", ndone, 1);
        chk("valid_gaps", gaps, 0);
        @(negedge clk);
        chk("done_single", longint'(done), 0);
        chk("busy_idle", longint'(busy), 0);
        chk("valid_idle", longint'(wr_if.wr_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        int v0 [8] = '{-120, -64, -1, 0, 1, 7, 1000, 35};
        int v3 [8] = '{-32768, 32767, -2, 2, -3, 3, 100, -100};

        for (int c = 0; c < 8; c++) begin
            tbl[0].in_v[c] = 16'(v0[c]);   tbl[0].exp_v[c] = 16'(v0[c]);
            tbl[1].in_v[c] = 16'(32767);   tbl[1].exp_v[c] = 16'(32767);
            tbl[2].in_v[c] = 16'(-32768);  tbl[2].exp_v[c] = 16'(-32768);
            tbl[3].in_v[c] = 16'(v3[c]);   tbl[3].exp_v[c] = 16'(v3[c]);
        end

        rst            = 1'b1;
        clk_fs         = 1'b0;
        start          = 1'b0;
        wr_if.wr_ready = 1'b1;
        for (int c = 0; c < 8; c++) in_s[c] = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", longint'(wr_if.wr_valid), 0);
        chk("rst_addr", longint'(wr_if.wr_addr), 0);
        chk("rst_data", longint'(wr_if.wr_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Constant-input table: the average must reproduce the input exactly.
        for (int t = 0; t < 4; t++) begin
            for (int f = 0; f < NF; f++)
                for (int c = 0; c < 8; c++) fr[f][c] = int'($signed(tbl[t].in_v[c]));
            for (int c = 0; c < 8; c++) exp_d[c] = int'($signed(tbl[t].exp_v[c]));
            capture(-1);
            collect(-1, 0);
        end

        // Rounding: 10+11+10+11 = 42 -> 11 ; -11-10-11-10 = -42 -> -10.
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 8; c++) fr[f][c] = (c == 3) ? ((f % 2 == 0) ? 10 : 11) : 0;
        for (int c = 0; c < 8; c++) exp_d[c] = (c == 3) ? 11 : 0;
        capture(-1);
        collect(-1, 0);
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 8; c++) fr[f][c] = (c == 3) ? ((f % 2 == 0) ? -11 : -10) : 0;
        for (int c = 0; c < 8; c++) exp_d[c] = (c == 3) ? -10 : 0;
        capture(-1);
        collect(-1, 0);

        // Backpressure at channel 2 for 5 cycles, random data.
        rand_frames();
        model();
        capture(-1);
        collect(2, 5);

        // Reset after 3 accepted words, then a fresh capture.
        begin
            int acc3 = 0;
            int cyc  = 0;
            int nd   = 0;
            int nv   = 0;
            for (int f = 0; f < NF; f++)
                for (int c = 0; c < 8; c++) fr[f][c] = c * 100 - 300;
            capture(-1);
            while (acc3 < 3 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (wr_if.wr_valid) acc3++;
            end
            chk("abort_words", acc3, 3);
            @(negedge clk);
            rst            = 1'b1;
            wr_if.wr_ready = 1'b0;
            @(negedge clk);
            chk("abort_valid", longint'(wr_if.wr_valid), 0);
            chk("abort_busy", longint'(busy), 0);
            rst            = 1'b0;
            wr_if.wr_ready = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (done) nd++;
                if (wr_if.wr_valid) nv++;
            end
            chk("abort_no_done", nd, 0);
            chk("abort_no_valid", nv, 0);
            rand_frames();
            model();
            capture(-1);
            collect(-1, 0);
        end

        // start pulsed during ACCUM must not restart the capture.
        rand_frames();
        model();
        capture(1);
        collect(-1, 0);

        // Random captures with a random stall point.
        for (int r = 0; r < 2; r++) begin
            rand_frames();
            model();
            capture(-1);
            collect(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
        end

`ifdef CAL_CAPTURE_NOISE_EN
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < 8; c++) fr[f][c] = (c == 5) ? ((f % 2 == 0) ? 100 : -100) : 7;
        model();
        capture(-1);
        collect(-1, 0);
        chk("noisy_flags", longint'(noisy), 8'b0010_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
